dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Data-memory stage directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUResult as the byte address and WriteData as store data; returns ReadData.
- Adds a request/ready handshake with configurable wait states, little-endian byte/word access and alignment checking.
- Stall tells the core to hold its PC and register writes until the access completes.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words of RAM; power of two, minimum 4.
- WAIT_CYCLES, 1, extra wait states per access; range 0..7.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- MemReq  input  1  access request; held by the core until MemReady.
- MemWrite  input  1  1 = store, 0 = load; valid with MemReq.
- ByteAcc  input  1  1 = byte access (LDRB/STRB), 0 = word access.
- Addr  input  32  byte address, driven from ALUResult.
- WriteData  input  32  store data; byte stores use WriteData[7:0].
- ReadData  output  32  load result; held until the next completed load.
- MemReady  output  1  one-cycle completion pulse.
- Stall  output  1  combinational: MemReq & ~MemReady.
- AlignFault  output  1  sticky misalignment flag.
- LedOut  output  8  MMIO register; present only with DMEM_MMIO_EN.

Behaviour:
- Reset values: ReadData=0, MemReady=0, AlignFault=0, LedOut=0, state=IDLE, wait counter=0.
- Reset does not clear RAM contents.
- States: IDLE, WAIT, DONE.
- IDLE, edge with MemReq=1, ByteAcc=0 and Addr[1:0]!=0:
  - Set AlignFault and go to DONE.
  - No RAM access; ReadData is forced to 0.
- IDLE, edge with any other MemReq=1:
  - Latch Addr, WriteData, MemWrite and ByteAcc.
  - Load counter=WAIT_CYCLES and go to WAIT.
- WAIT, each edge:
  - If counter==0: perform the access and go to DONE.
  - Otherwise decrement the counter.
- DONE: MemReady=1 for exactly this cycle; the next edge returns to IDLE unconditionally.
- A new request can be accepted no earlier than the edge after DONE.
- Latency: request sampled at edge N gives MemReady high in the cycle after edge N+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles after the request is presented. A misaligned request takes 1 cycle.
- Stall is high from the cycle MemReq is presented until the DONE cycle, and low in DONE.
- Word index is Addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Word store writes all 4 lanes.
- Byte store writes only lane Addr[1:0] (lane 0 = bits 7:0); other lanes are unchanged.
- Word load returns the full word.
- Byte load returns the lane, zero-extended: ReadData = {24'b0, byte}.
- Stores leave ReadData unchanged.
- AlignFault stays high until reset; later accesses still proceed normally.
- MemReq dropping mid-access is ignored: the latched access completes and MemReady still pulses.
- Reset in WAIT or DONE:
  - Abort to IDLE; a pending store is discarded (RAM is not written).
  - MemReady is low on the next cycle.
- RAM is a single synchronous array with the write and the read capture on the same edge; read-during-write is impossible, since one access is active at a time.

Optional Feature:
DMEM_MMIO_EN
- Defined:
  - Address 0xFFFF_FF00 is an MMIO LED register that bypasses RAM and uses the same timing.
  - Word store: LedOut <= WriteData[7:0].
  - Word load: ReadData = {24'b0, LedOut}.
  - Byte access to 0xFFFF_FF00..03 behaves like the word access on lane 0; other lanes read 0 and ignore writes.
- Undefined:
  - The LedOut port is absent.
  - 0xFFFF_FF00 wraps into RAM like any other address.

Test Plan:
- WAIT_CYCLES=1, after reset:
  - Word store 0x12345678 to 0x10 -> MemReady 3 cycles after request, Stall high for cycles 1–2.
  - Word load 0x10 -> ReadData=0x12345678.
- After the above, STRB 0xAB to 0x11 -> word load 0x10 returns 0x1234AB78; LDRB 0x13 returns 0x00000012.
- Word load at 0x22:
  - AlignFault=1, ReadData=0, MemReady 1 cycle after request.
  - Word 0x20 unchanged.
  - AlignFault still 1 after a later good access; cleared only by reset.
- Word 0x20 holds 0xCAFEF00D; store 0xDEADBEEF to 0x20 with reset pulsed during WAIT:
  - No MemReady; outputs return to reset values.
  - A subsequent load of 0x20 returns 0xCAFEF00D.
- WAIT_CYCLES=0, DEPTH_WORDS=64:
  - Store 0x0000BEEF to 0x100 -> MemReady 2 cycles after request.
  - Load 0x000 returns 0x0000BEEF (wrap).
- DMEM_MMIO_EN defined:
  - Store 0x000000A5 to 0xFFFFFF00 -> LedOut=0xA5; load returns 0x000000A5.
  - RAM word 0 (0x00000000 after a write of zero) unchanged.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory stage with request/ready handshake, wait states, byte/word access and alignment check.
// Optional DMEM_MMIO_EN maps an 8-bit LED register at 0xFFFF_FF00 in place of RAM.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic        ByteAcc,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        Stall,
  output logic        AlignFault,
`ifdef DMEM_MMIO_EN
  output logic [7:0]  LedOut,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: the core raises MemReq with MemWrite/ByteAcc/Addr/WriteData valid and
  // holds it until MemReady; MemReady pulses for exactly one cycle per accepted request.

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wd_q;
  logic          we_q;
  logic          bt_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx_q;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    byte_val;
  logic [31:0]   load_data;
  logic          is_mmio;
  logic          do_access;

  assign idx_q     = addr_q[AW+1:2];
  assign lane      = addr_q[1:0];
  assign do_access = (state == S_WAIT) && (cnt == 3'd0);
  assign MemReady  = (state == S_DONE);
  assign Stall     = MemReq & ~MemReady;
  assign dbg_state = state;

`ifdef DMEM_MMIO_EN
  assign is_mmio = (addr_q[31:2] == 30'h3FFF_FFC0);
`else
  logic unused_addr_bits;
  assign is_mmio          = 1'b0;
  assign unused_addr_bits = ^addr_q[31:AW+2];
`endif

  always_comb begin
    rd_word   = mem[idx_q];
    byte_val  = rd_word[{lane, 3'b000} +: 8];
    load_data = bt_q ? {24'b0, byte_val} : rd_word;
`ifdef DMEM_MMIO_EN
    // Only lane 0 of the LED register exists; other byte lanes read as zero.
    if (is_mmio) load_data = (bt_q && lane != 2'd0) ? 32'd0 : {24'b0, LedOut};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      ReadData   <= 32'd0;
      AlignFault <= 1'b0;
      addr_q     <= 32'd0;
      wd_q       <= 32'd0;
      we_q       <= 1'b0;
      bt_q       <= 1'b0;
`ifdef DMEM_MMIO_EN
      LedOut     <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (MemReq) begin
            if (!ByteAcc && Addr[1:0] != 2'b00) begin
              AlignFault <= 1'b1;
              ReadData   <= 32'd0;
              state      <= S_DONE;
            end else begin
              addr_q <= Addr;
              wd_q   <= WriteData;
              we_q   <= MemWrite;
              bt_q   <= ByteAcc;
              cnt    <= 3'(WAIT_CYCLES);
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state <= S_DONE;
            if (!we_q) ReadData <= load_data;
`ifdef DMEM_MMIO_EN
            if (we_q && is_mmio && (!bt_q || lane == 2'd0)) LedOut <= wd_q[7:0];
`endif
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset on the access edge discards the pending store.
  always_ff @(posedge clk) begin
    if (!reset && do_access && we_q && !is_mmio) begin
      if (bt_q) mem[idx_q][{lane, 3'b000} +: 8] <= wd_q[7:0];
      else      mem[idx_q] <= wd_q;
    end
  end

endmodule
